// File: rtl/calc_seq_pkg.sv
// Shared definitions for the calculation-stage sequencer.
// Holds the opcode and FSM state enums, the instruction field positions,
// the mux_sta encodings and the decoded control bundle type.
package calc_seq_pkg;

  typedef enum logic [1:0] {
    OpcPushV = 2'b00,
    OpcLutOp = 2'b01,
    OpcAcc   = 2'b10,
    OpcEnd   = 2'b11
  } opc_e;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  // Instruction word layout: [9:8] opc, [7:6] op, [5] pop, [4] val, [3:0] lut.
  localparam int unsigned OpcMsb = 9;
  localparam int unsigned OpcLsb = 8;
  localparam int unsigned OpMsb  = 7;
  localparam int unsigned OpLsb  = 6;
  localparam int unsigned PopBit = 5;
  localparam int unsigned ValBit = 4;
  localparam int unsigned LutMsb = 3;
  localparam int unsigned LutLsb = 0;

  // Stack-input mux selects.
  localparam logic [1:0] MuxIdle = 2'b00;
  localparam logic [1:0] MuxPush = 2'b00;
  localparam logic [1:0] MuxLut  = 2'b10;
  localparam logic [1:0] MuxAcc  = 2'b11;

  typedef struct packed {
    logic       en_push_force;
    logic       en_pop;
    logic       en_push;
    logic       en_stack_wr;
    logic [1:0] mux_sta;
    logic [1:0] op;
    logic [3:0] lut;
    logic       val;
    logic       do_pop;
    logic       ld_op;     // field registers to update on issue
    logic       ld_lut;
    logic       ld_val;
    logic       ld_pop;
    logic       toggle;    // instruction flips the cycle phase
    logic       is_end;
    logic       stk_push;  // net occupancy effect for the depth checker
    logic       stk_pop;
  } ctrl_t;

endpackage

// File: rtl/calc_sequencer_if.sv
// Instruction and result handshake bundle of the sequencer.
//   in_valid/in_ready/in_instr : instruction stream into the sequencer
//   res_valid/res_ready/res_data : one-bit program result out of it
// master = program source / result sink, slave = calc_sequencer.
interface calc_sequencer_if #(
  parameter int unsigned INSTR_W = 10
) ();

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic               res_valid;
  logic               res_ready;
  logic               res_data;

  modport master (
    output in_valid, in_instr, res_ready,
    input  in_ready, res_valid, res_data
  );

  modport slave (
    input  in_valid, in_instr, res_ready,
    output in_ready, res_valid, res_data
  );

endinterface

// File: rtl/calc_seq_decode.sv
// Purely combinational instruction decoder.
//   instr : instruction word
//   ctrl  : control bundle (enables, mux select, field values, load masks)
module calc_seq_decode
  import calc_seq_pkg::*;
#(
  parameter int unsigned INSTR_W = 10
) (
  input  logic [INSTR_W-1:0] instr,
  output ctrl_t              ctrl
);

  always_comb begin
    ctrl        = '0;
    ctrl.op     = instr[OpMsb:OpLsb];
    ctrl.lut    = instr[LutMsb:LutLsb];
    ctrl.val    = instr[ValBit];
    ctrl.do_pop = instr[PopBit];
    unique case (opc_e'(instr[OpcMsb:OpcLsb]))
      OpcPushV: begin
        ctrl.en_push_force = 1'b1;
        ctrl.en_stack_wr   = 1'b1;
        ctrl.mux_sta       = MuxPush;
        ctrl.ld_val        = 1'b1;
        ctrl.toggle        = 1'b1;
        ctrl.stk_push      = 1'b1;
      end
      OpcLutOp: begin
        // Pop-and-push replaces the top; the pop field drops one more entry.
        ctrl.en_pop      = 1'b1;
        ctrl.en_push     = 1'b1;
        ctrl.en_stack_wr = 1'b1;
        ctrl.mux_sta     = MuxLut;
        ctrl.ld_op       = 1'b1;
        ctrl.ld_lut      = 1'b1;
        ctrl.ld_pop      = 1'b1;
        ctrl.toggle      = 1'b1;
        ctrl.stk_pop     = instr[PopBit];
      end
      OpcAcc: begin
        ctrl.en_stack_wr = 1'b1;
        ctrl.mux_sta     = MuxAcc;
        ctrl.ld_op       = 1'b1;
        ctrl.ld_val      = 1'b1;
        ctrl.toggle      = 1'b1;
        ctrl.stk_pop     = instr[PopBit];
      end
      OpcEnd: begin
        ctrl.is_end = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/calc_sequencer.sv
// Sequencer driving the calculation stage from an instruction stream.
//   clk, reset : clock, synchronous active-high reset
//   start      : pulse, starts a program when idle
//   bus        : instruction/result handshakes (calc_sequencer_if.slave)
//   stk_top    : bit 0 of the stage's out_stack, captured as the result
//   cycle, do_pop, val, en_*, op, mux_sta, lut : registered stage controls
//   err        : sticky stack overflow/underflow flag
// Optional feature: define CALC_SEQ_DEPTH_CHECK_EN to track per-phase stack
// occupancy against DEPTH and flag overflow/underflow; otherwise err is 0.
module calc_sequencer
  import calc_seq_pkg::*;
#(
  parameter int unsigned DEPTH   = 6,
  parameter int unsigned INSTR_W = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  calc_sequencer_if.slave bus,
  input  logic            stk_top,
  output logic            cycle,
  output logic            do_pop,
  output logic            val,
  output logic            en_push_force,
  output logic            en_pop,
  output logic            en_push,
  output logic            en_stack_wr,
  output logic [1:0]      op,
  output logic [1:0]      mux_sta,
  output logic [3:0]      lut,
  output logic            err
);

  state_e state_q, state_d;
  ctrl_t  dec;
  logic   accept;

  logic       cycle_q, do_pop_q, val_q, res_data_q;
  logic       en_push_force_q, en_pop_q, en_push_q, en_stack_wr_q;
  logic [1:0] op_q, mux_sta_q;
  logic [3:0] lut_q;

  calc_seq_decode #(
    .INSTR_W(INSTR_W)
  ) u_decode (
    .instr(bus.in_instr),
    .ctrl (dec)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (accept && dec.is_end) state_d = StDrain;
      StDrain: state_d = StDone;
      StDone:  if (bus.res_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.res_valid = 1'b0;
    unique case (state_q)
      StRun:   bus.in_ready  = 1'b1;
      StDone:  bus.res_valid = 1'b1;
      default: ;
    endcase
  end

  assign accept       = bus.in_valid & bus.in_ready;
  assign bus.res_data = res_data_q;

  // Stage controls: enables pulse for one cycle per issue, field values
  // persist across bubbles so the stage sees stable operands.
  always_ff @(posedge clk) begin
    if (reset) begin
      en_push_force_q <= 1'b0;
      en_pop_q        <= 1'b0;
      en_push_q       <= 1'b0;
      en_stack_wr_q   <= 1'b0;
      mux_sta_q       <= MuxIdle;
      op_q            <= '0;
      lut_q           <= '0;
      val_q           <= 1'b0;
      do_pop_q        <= 1'b0;
      cycle_q         <= 1'b0;
      res_data_q      <= 1'b0;
    end else begin
      en_push_force_q <= accept & dec.en_push_force;
      en_pop_q        <= accept & dec.en_pop;
      en_push_q       <= accept & dec.en_push;
      en_stack_wr_q   <= accept & dec.en_stack_wr;
      mux_sta_q       <= accept ? dec.mux_sta : MuxIdle;
      if (accept && dec.ld_op)  op_q     <= dec.op;
      if (accept && dec.ld_lut) lut_q    <= dec.lut;
      if (accept && dec.ld_val) val_q    <= dec.val;
      if (accept && dec.ld_pop) do_pop_q <= dec.do_pop;
      if (accept && dec.toggle) cycle_q  <= ~cycle_q;
      // DRAIN always exits to DONE, so this is the DRAIN->DONE edge.
      if (state_q == StDrain) res_data_q <= stk_top;
    end
  end

  assign cycle         = cycle_q;
  assign do_pop        = do_pop_q;
  assign val           = val_q;
  assign en_push_force = en_push_force_q;
  assign en_pop        = en_pop_q;
  assign en_push       = en_push_q;
  assign en_stack_wr   = en_stack_wr_q;
  assign op            = op_q;
  assign mux_sta       = mux_sta_q;
  assign lut           = lut_q;

`ifdef CALC_SEQ_DEPTH_CHECK_EN
  localparam int unsigned   CntW   = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEPTH);

  // One occupancy counter per cycle phase, indexed by the phase in which
  // the instruction issues. Counters saturate; violations latch err.
  logic [CntW-1:0] cnt_q [2];
  logic            err_q;

  always_ff @(posedge clk) begin
    if (reset || (state_q == StIdle && start)) begin
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
      err_q    <= 1'b0;
    end else if (accept) begin
      if (dec.stk_pop) begin
        if (cnt_q[cycle_q] == '0) err_q <= 1'b1;
        else cnt_q[cycle_q] <= cnt_q[cycle_q] - CntW'(1);
      end else if (dec.stk_push) begin
        if (cnt_q[cycle_q] == CntMax) err_q <= 1'b1;
        else cnt_q[cycle_q] <= cnt_q[cycle_q] + CntW'(1);
      end
    end
  end

  assign err = err_q;
`else
  logic unused_depth;
  assign unused_depth = ^{dec.stk_push, dec.stk_pop};
  assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_calc_sequencer.sv
module tb_calc_sequencer;

`ifdef CALC_SEQ_DEPTH_CHECK_EN
  localparam int unsigned TbDepth = 2;
`else
  localparam int unsigned TbDepth = 6;
`endif

  localparam logic [9:0] PushV1 = 10'b00_00_0_1_0000;
  localparam logic [9:0] PushV0 = 10'b00_00_0_0_0000;
  localparam logic [9:0] LutI   = 10'b01_10_1_0_0100; // op=2 pop=1 lut=0100
  localparam logic [9:0] AccI   = 10'b10_11_0_1_0000; // op=3 val=1 no pop
  localparam logic [9:0] AccI2  = 10'b10_10_0_1_0000; // op=2 val=1 no pop
  localparam logic [9:0] EndI   = 10'b11_00_0_0_0000;

  logic clk = 1'b0;
  logic reset, start, stk_top;
  logic cycle, do_pop, val, en_push_force, en_pop, en_push, en_stack_wr, err;
  logic [1:0] op, mux_sta;
  logic [3:0] lut;

  calc_sequencer_if #(.INSTR_W(10)) bus ();

  calc_sequencer #(
    .DEPTH  (TbDepth),
    .INSTR_W(10)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .bus          (bus),
    .stk_top      (stk_top),
    .cycle        (cycle),
    .do_pop       (do_pop),
    .val          (val),
    .en_push_force(en_push_force),
    .en_pop       (en_pop),
    .en_push      (en_push),
    .en_stack_wr  (en_stack_wr),
    .op           (op),
    .mux_sta      (mux_sta),
    .lut          (lut),
    .err          (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] ens;  // {en_push_force, en_pop, en_push, en_stack_wr}
    logic [1:0] mux;
    logic [1:0] op;
    logic [3:0] lut;
    logic       val;
    logic       pop;
    logic       cycle;
  } issue_t;

  typedef struct {
    int   cyc;
    logic data;
  } res_t;

  issue_t ctrl_q[$];
  res_t   res_q[$];

  // Model of the held stage fields and flags.
  logic [1:0] m_op;
  logic [3:0] m_lut;
  logic       m_val, m_pop, m_cycle, m_err;
  bit         mon_en = 0;
  logic       prev_rv = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fails++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  // Monitor: an issue cycle pops the control scoreboard, any other cycle
  // must be a bubble holding the last fields; a rising res_valid pops results.
  always @(negedge clk) begin
    issue_t     e;
    res_t       r;
    logic [3:0] ens;
    if (mon_en) begin
      ens = {en_push_force, en_pop, en_push, en_stack_wr};
      if (ctrl_q.size() > 0 && ctrl_q[0].cyc <= cyc) begin
        e = ctrl_q.pop_front();
        check("issue_cycle_no", cyc, e.cyc);
        check("issue_enables", {28'd0, ens}, {28'd0, e.ens});
        check("issue_mux_sta", {30'd0, mux_sta}, {30'd0, e.mux});
        check("issue_fields", {23'd0, op, lut, val, do_pop},
              {23'd0, e.op, e.lut, e.val, e.pop});
        check("issue_cycle", {31'd0, cycle}, {31'd0, e.cycle});
      end else begin
        check("bubble_enables", {28'd0, ens}, 32'd0);
        check("bubble_mux_sta", {30'd0, mux_sta}, 32'd0);
        check("bubble_fields", {24'd0, op, lut, val, do_pop},
              {24'd0, m_op, m_lut, m_val, m_pop});
        check("bubble_cycle", {31'd0, cycle}, {31'd0, m_cycle});
      end
      check("err", {31'd0, err}, {31'd0, m_err});
      if (bus.res_valid === 1'b1 && prev_rv !== 1'b1) begin
        if (res_q.size() == 0) begin
          check("unexpected_res_valid", 32'd1, 32'd0);
        end else begin
          r = res_q.pop_front();
          check("res_valid_cycle_no", cyc, r.cyc);
          check("res_data", {31'd0, bus.res_data}, {31'd0, r.data});
        end
      end
      prev_rv = bus.res_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_op = '0; m_lut = '0; m_val = 1'b0; m_pop = 1'b0; m_cycle = 1'b0; m_err = 1'b0;
    ctrl_q.delete();
    res_q.delete();
    prev_rv = 1'b0;
  endtask

  task automatic check_reset_vals();
    @(negedge clk);
    check("rst_cycle", {31'd0, cycle}, 32'd0);
    check("rst_enables", {28'd0, en_push_force, en_pop, en_push, en_stack_wr}, 32'd0);
    check("rst_mux_sta", {30'd0, mux_sta}, 32'd0);
    check("rst_op", {30'd0, op}, 32'd0);
    check("rst_lut", {28'd0, lut}, 32'd0);
    check("rst_val_pop", {30'd0, val, do_pop}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    check("rst_res_data", {31'd0, bus.res_data}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
  endtask

  task automatic start_prog();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic bubble(input int n);
    bus.in_valid = 1'b0;
    repeat (n) tick();
  endtask

  // Offer one instruction, wait for acceptance, then record expectations.
  task automatic send(input logic [9:0] instr);
    bit     accepted = 0;
    issue_t e;
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    for (int i = 0; i < 20 && !accepted; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) accepted = 1;
      tick();
    end
    bus.in_valid = 1'b0;
    if (!accepted) begin
      fail_now("accept");
      return;
    end
    e.cyc = cyc;
    unique case (instr[9:8])
      2'b00: begin m_val = instr[4]; e.ens = 4'b1001; e.mux = 2'b00; end
      2'b01: begin
        m_op = instr[7:6]; m_lut = instr[3:0]; m_pop = instr[5];
        e.ens = 4'b0111; e.mux = 2'b10;
      end
      2'b10: begin m_op = instr[7:6]; m_val = instr[4]; e.ens = 4'b0001; e.mux = 2'b11; end
      default: begin e.ens = 4'b0000; e.mux = 2'b00; end
    endcase
    if (instr[9:8] != 2'b11) begin
      m_cycle = ~m_cycle;
      e.op = m_op; e.lut = m_lut; e.val = m_val; e.pop = m_pop; e.cycle = m_cycle;
      ctrl_q.push_back(e);
    end else begin
      res_q.push_back('{cyc: cyc + 1, data: stk_top});
    end
  endtask

  // Wait for DONE, keep res_ready low for `hold` cycles, then handshake.
  task automatic finish_prog(input int hold, input logic exp_data);
    bit seen = 0;
    bus.res_ready = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.res_valid === 1'b1) seen = 1;
    end
    if (!seen) begin
      fail_now("res_valid");
      return;
    end
    for (int i = 0; i < hold; i++) begin
      check("hold_res_valid", {31'd0, bus.res_valid}, 32'd1);
      check("hold_res_data", {31'd0, bus.res_data}, {31'd0, exp_data});
      check("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
      @(negedge clk);
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    @(negedge clk);
    check("idle_res_valid", {31'd0, bus.res_valid}, 32'd0);
    check("idle_in_ready", {31'd0, bus.in_ready}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; stk_top = 1'b0;
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.res_ready = 1'b0;
    model_reset();
    repeat (3) tick();
    reset = 1'b0;
    check_reset_vals();
    mon_en = 1;

    // Two pushes then END; result captured from stk_top.
    stk_top = 1'b1;
    start_prog();
    send(PushV1);
    send(PushV0);
    send(EndI);
    finish_prog(0, 1'b1);

    // LUT_OP issue, then result held while res_ready stays low.
    stk_top = 1'b0;
    start_prog();
    send(PushV1);
    send(PushV0);
    send(LutI);
    bubble(2);
    send(EndI);
    finish_prog(5, 1'b0);

    // Gapped instruction stream with start held high during RUN.
    stk_top = 1'b1;
    start_prog();
    start = 1'b1;
    send(PushV1);
    bubble(1);
    send(AccI);
    bubble(2);
    send(PushV0);
    bubble(1);
    send(AccI);
    start = 1'b0;
    send(EndI);
    finish_prog(2, 1'b1);

    // Reset mid-RUN after two issues, with a third instruction on offer.
    start_prog();
    send(PushV1);
    send(AccI2);
    bus.in_valid = 1'b1;
    bus.in_instr = PushV1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    model_reset();
    check_reset_vals();
    repeat (2) tick();
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);

`ifdef CALC_SEQ_DEPTH_CHECK_EN
    // Two pushes per phase fill DEPTH=2; the fifth overflows.
    stk_top = 1'b0;
    start_prog();
    for (int i = 0; i < 4; i++) send(PushV1);
    send(PushV0);
    m_err = 1'b1;
    send(EndI);
    finish_prog(1, 1'b0);
    bubble(2);
`endif

    // Fresh program after reset (also clears a latched err).
    stk_top = 1'b1;
    start_prog();
    send(PushV1);
    send(EndI);
    finish_prog(1, 1'b1);

    repeat (2) tick();
    check("ctrl_queue_empty", ctrl_q.size(), 32'd0);
    check("res_queue_empty", res_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
